// File: rtl/bsg_manycore_proc_ingress.sv
// Ingress front-end: packet FIFO, head decode, imem/dmem store steering and a load-reserved table.
// Define BSG_MANYCORE_INGRESS_STATS_EN to add imem_store_cnt_o/dmem_store_cnt_o commit counters.
module bsg_manycore_proc_ingress #(
    parameter int addr_width_p      = 32,
    parameter int data_width_p      = 32,
    parameter int els_p             = 4,
    parameter int imem_addr_width_p = 12,
    parameter int num_resv_p        = 2,
    parameter int packet_width_lp   = 2 + addr_width_p + data_width_p/8 + data_width_p
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          v_i,
    input  logic [packet_width_lp-1:0]    data_i,
    output logic                          ready_o,
    output logic                          imem_v_o,
    output logic [imem_addr_width_p-1:0]  imem_addr_o,
    output logic [data_width_p-1:0]       imem_data_o,
    output logic [data_width_p/8-1:0]     imem_mask_o,
    input  logic                          imem_yumi_i,
    output logic                          dmem_v_o,
    output logic [addr_width_p-3:0]       dmem_addr_o,
    output logic [data_width_p-1:0]       dmem_data_o,
    output logic [data_width_p/8-1:0]     dmem_mask_o,
    input  logic                          dmem_yumi_i,
    input  logic                          resv_v_i,
    input  logic [addr_width_p-3:0]       resv_addr_i,
    input  logic [addr_width_p-3:0]       resv_check_addr_i,
    output logic                          resv_hit_o,
    output logic                          freeze_o,
    output logic [7:0]                    unknown_cnt_o
`ifdef BSG_MANYCORE_INGRESS_STATS_EN
    ,
    output logic [31:0]                   imem_store_cnt_o,
    output logic [31:0]                   dmem_store_cnt_o
`endif
);

    localparam int mask_width_lp  = data_width_p / 8;
    localparam int ptr_width_lp   = $clog2(els_p);
    localparam int waddr_width_lp = addr_width_p - 2;
    localparam int rp_width_lp    = (num_resv_p > 1) ? $clog2(num_resv_p) : 1;

    typedef enum logic [1:0] {
        OP_STORE    = 2'b00,
        OP_FREEZE   = 2'b01,
        OP_UNFREEZE = 2'b10,
        OP_UNKNOWN  = 2'b11
    } op_e;

    // ---------------------------------------------------------------
    // FIFO: pointers carry one extra wrap bit to tell full from empty.
    // ---------------------------------------------------------------
    logic [packet_width_lp-1:0] mem [els_p];
    logic [ptr_width_lp:0]      wptr;
    logic [ptr_width_lp:0]      rptr;
    logic                       empty;
    logic                       full;
    logic                       enq;
    logic                       deq;
    logic [packet_width_lp-1:0] head;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[ptr_width_lp] != rptr[ptr_width_lp]) &&
                     (wptr[ptr_width_lp-1:0] == rptr[ptr_width_lp-1:0]);
    assign ready_o = ~full;
    assign enq     = v_i & ~full;
    assign head    = mem[rptr[ptr_width_lp-1:0]];

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr[ptr_width_lp-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (enq) wptr <= wptr + 1'b1;
            if (deq) rptr <= rptr + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Head decode
    // ---------------------------------------------------------------
    op_e                        head_op;
    logic [addr_width_p-1:0]    head_addr;
    logic [mask_width_lp-1:0]   head_mask;
    logic [data_width_p-1:0]    head_data;
    logic [waddr_width_lp-1:0]  store_waddr;
    logic                       imem_sel;
    logic                       is_store;
    logic                       do_freeze;
    logic                       do_unfreeze;
    logic                       do_unknown;
    logic                       imem_commit;
    logic                       dmem_commit;
    logic                       commit;

    assign head_op     = op_e'(head[1:0]);
    assign head_addr   = head[2 +: addr_width_p];
    assign head_mask   = head[2 + addr_width_p +: mask_width_lp];
    assign head_data   = head[2 + addr_width_p + mask_width_lp +: data_width_p];
    assign store_waddr = head_addr[addr_width_p-1:2];
    assign imem_sel    = ~|head_addr[addr_width_p-1:imem_addr_width_p+2];

    assign is_store    = ~empty & (head_op == OP_STORE);
    assign do_freeze   = ~empty & (head_op == OP_FREEZE);
    assign do_unfreeze = ~empty & (head_op == OP_UNFREEZE);
    assign do_unknown  = ~empty & (head_op == OP_UNKNOWN);

    // Valid/yumi handshake: imem_v_o/dmem_v_o and their payload come straight from the
    // FIFO head and hold until the consumer pulses the matching yumi while valid is high;
    // that cycle commits the store and pops the head. ready_o gates enqueue of v_i.
    assign imem_v_o    = is_store & imem_sel;
    assign dmem_v_o    = is_store & ~imem_sel;
    assign imem_addr_o = head_addr[imem_addr_width_p+1:2];
    assign imem_data_o = head_data;
    assign imem_mask_o = head_mask;
    assign dmem_addr_o = store_waddr;
    assign dmem_data_o = head_data;
    assign dmem_mask_o = head_mask;

    assign imem_commit = imem_v_o & imem_yumi_i;
    assign dmem_commit = dmem_v_o & dmem_yumi_i;
    assign commit      = imem_commit | dmem_commit;
    assign deq         = do_freeze | do_unfreeze | do_unknown | commit;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            freeze_o      <= 1'b1;
            unknown_cnt_o <= '0;
        end else begin
            if (do_freeze) begin
                freeze_o <= 1'b1;
            end else if (do_unfreeze) begin
                freeze_o <= 1'b0;
            end
            if (do_unknown && (unknown_cnt_o != 8'hFF)) begin
                unknown_cnt_o <= unknown_cnt_o + 8'd1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Load-reserved table
    // ---------------------------------------------------------------
    logic [num_resv_p-1:0]      resv_v_r;
    logic [num_resv_p-1:0]      resv_v_n;
    logic [waddr_width_lp-1:0]  resv_addr_r [num_resv_p];
    logic [rp_width_lp-1:0]     repl_ptr;
    logic [num_resv_p-1:0]      match_alloc;
    logic [num_resv_p-1:0]      match_store;
    logic [num_resv_p-1:0]      match_check;
    logic                       free_found;
    logic [rp_width_lp-1:0]     free_idx;
    logic [rp_width_lp-1:0]     alloc_idx;
    logic                       alloc_new;

    always_comb begin
        match_alloc = '0;
        match_store = '0;
        match_check = '0;
        for (int i = 0; i < num_resv_p; i++) begin
            match_alloc[i] = resv_v_r[i] & (resv_addr_r[i] == resv_addr_i);
            match_store[i] = resv_v_r[i] & (resv_addr_r[i] == store_waddr);
            match_check[i] = resv_v_r[i] & (resv_addr_r[i] == resv_check_addr_i);
        end
    end

    assign resv_hit_o = |match_check;

    // Scan from the top so the lowest-index invalid entry is the one left selected.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = num_resv_p - 1; i >= 0; i--) begin
            if (!resv_v_r[i]) begin
                free_found = 1'b1;
                free_idx   = rp_width_lp'(i);
            end
        end
    end

    assign alloc_new = resv_v_i & ~|match_alloc;
    assign alloc_idx = free_found ? free_idx : repl_ptr;

    // Order encodes priority: store clear, then allocation, then freeze.
    always_comb begin
        resv_v_n = resv_v_r;
        if (commit) begin
            resv_v_n = resv_v_n & ~match_store;
        end
        if (resv_v_i) begin
            resv_v_n = resv_v_n | match_alloc;
        end
        if (alloc_new) begin
            resv_v_n[alloc_idx] = 1'b1;
        end
        if (do_freeze) begin
            resv_v_n = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resv_v_r <= '0;
            repl_ptr <= '0;
            for (int i = 0; i < num_resv_p; i++) begin
                resv_addr_r[i] <= '0;
            end
        end else begin
            resv_v_r <= resv_v_n;
            if (alloc_new && !do_freeze) begin
                resv_addr_r[alloc_idx] <= resv_addr_i;
                if (!free_found) begin
                    if (repl_ptr == rp_width_lp'(num_resv_p - 1)) begin
                        repl_ptr <= '0;
                    end else begin
                        repl_ptr <= repl_ptr + 1'b1;
                    end
                end
            end
        end
    end

`ifdef BSG_MANYCORE_INGRESS_STATS_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            imem_store_cnt_o <= '0;
            dmem_store_cnt_o <= '0;
        end else begin
            if (imem_commit) imem_store_cnt_o <= imem_store_cnt_o + 32'd1;
            if (dmem_commit) dmem_store_cnt_o <= dmem_store_cnt_o + 32'd1;
        end
    end
`endif

endmodule
